// File: rtl/mult_sched_pkg.sv
// Shared definitions for the round-robin multiplier scheduler: FSM encoding,
// default sizing and the requester-ID width helper.
package mult_sched_pkg;

    localparam int NREQ_DEF    = 4;
    localparam int WIDTH_DEF   = 32;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // A single requester still needs a 1-bit ID field.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mult_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr_i,
// wrapping modulo NREQ. Returns both a one-hot grant and the winner's index.
module rr_arbiter
    import mult_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = id_width(NREQ_DEF)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o,
    output logic            valid_o
);

    logic [IDW-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(ptr_i) + k) % NREQ);
            if (!valid_o && req_i[cand]) begin
                grant_o[cand] = 1'b1;
                idx_o         = cand;
                valid_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_sched.sv
// Round-robin scheduler that time-shares one sequential signed multiplier
// among NREQ requesters and returns each product on a shared response port.
module mult_sched
    import mult_sched_pkg::*;
#(
    parameter  int NREQ    = NREQ_DEF,
    parameter  int WIDTH   = WIDTH_DEF,
    parameter  int TIMEOUT = TIMEOUT_DEF,
    localparam int IDW     = id_width(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // Handshake rule on every channel here: a transfer happens on a rising
    // clk edge where valid and ready are both high; valid and its payload must
    // stay stable until that edge, and ready may depend combinationally on valid.
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [IDW-1:0]          resp_id,
    output logic [2*WIDTH-1:0]      resp_data,
    output logic                    resp_err,
    output logic                    m_start,
    output logic [WIDTH-1:0]        m_a,
    output logic [WIDTH-1:0]        m_b,
    input  logic                    m_done,
    input  logic [WIDTH-1:0]        m_lo,
    input  logic [WIDTH-1:0]        m_hi,
    output state_e                  dbg_state_o
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     gid_q, gid_d;
    logic [WIDTH-1:0]   ma_q, ma_d;
    logic [WIDTH-1:0]   mb_q, mb_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] rdata_q, rdata_d;
    logic               rerr_q, rerr_d;

    logic [NREQ-1:0]    arb_grant;
    logic [IDW-1:0]     arb_idx;
    logic               arb_valid;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gid_q   <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gid_d      = gid_q;
        ma_d       = ma_q;
        mb_d       = mb_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        rerr_d     = rerr_q;
        req_ready  = '0;
        m_start    = 1'b0;
        resp_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Ready is combinational on valid; keep it quiet while reset is held.
                if (arb_valid && rst_n) begin
                    req_ready = arb_grant;
                    gid_d     = arb_idx;
                    ma_d      = req_a[arb_idx*WIDTH +: WIDTH];
                    mb_d      = req_b[arb_idx*WIDTH +: WIDTH];
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                m_start = 1'b1;
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A completion on the last watchdog cycle still counts as success.
                if (m_done) begin
                    rdata_d = {m_hi, m_lo};
                    rerr_d  = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    rerr_d  = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    ptr_d   = (gid_q == IDW'(NREQ - 1)) ? '0 : gid_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign resp_id     = gid_q;
    assign resp_data   = rdata_q;
    assign resp_err    = rerr_q;
    assign m_a         = ma_q;
    assign m_b         = mb_q;
    assign dbg_state_o = state_q;

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));

endmodule

// File: tb/tb_mult_sched.sv
// Randomized bench for mult_sched with a behavioural multiplier and a
// cycle-level transaction model of the scheduler's round-robin contract.
module tb_mult_sched;
    import mult_sched_pkg::*;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 64;
    localparam int IDW     = 2;
    localparam int W       = 1 + IDW + 2*WIDTH;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NREQ-1:0]       req_valid, req_ready;
    logic [NREQ*WIDTH-1:0] req_a, req_b;
    logic                  resp_valid, resp_ready, resp_err;
    logic [IDW-1:0]        resp_id;
    logic [2*WIDTH-1:0]    resp_data;
    logic                  m_start, m_done;
    logic [WIDTH-1:0]      m_a, m_b, m_lo, m_hi;
    state_e                dbg_state;

    mult_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .m_start    (m_start),
        .m_a        (m_a),
        .m_b        (m_b),
        .m_done     (m_done),
        .m_lo       (m_lo),
        .m_hi       (m_hi),
        .dbg_state_o(dbg_state)
    );

    // ---------------- multiplier model ----------------
    int          mm_lat;
    logic        mm_hang, mm_spur;
    logic        mm_busy;
    int          mm_cnt;
    logic [63:0] mm_prod;
    logic        mm_spur_now;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mm_busy <= 1'b0;
            mm_cnt  <= 0;
            mm_prod <= '0;
        end else if (m_start) begin
            mm_busy <= 1'b1;
            mm_cnt  <= mm_lat;
            mm_prod <= {{32{m_a[31]}}, m_a} * {{32{m_b[31]}}, m_b};
        end else if (mm_busy && !mm_hang) begin
            if (mm_cnt == 0) mm_busy <= 1'b0;
            else             mm_cnt  <= mm_cnt - 1;
        end
    end

    // Optional garbage completion during the start pulse must be ignored.
    assign mm_spur_now = mm_spur && m_start;
    assign m_done = (mm_busy && !mm_hang && mm_cnt == 0) || mm_spur_now;
    assign m_lo   = mm_spur_now ? 32'hDEAD_BEEF : mm_prod[31:0];
    assign m_hi   = mm_spur_now ? 32'h0BAD_F00D : mm_prod[63:32];

    // ---------------- scoreboard / model state ----------------
    int              n_checks = 0;
    int              n_pass   = 0;
    logic [W-1:0]    exp_q[$];
    logic [NREQ-1:0] pend;
    logic [WIDTH-1:0] pa[NREQ];
    logic [WIDTH-1:0] pb[NREQ];
    int              m_ptr;
    bit              busy_op, exp_start, waiting, exp_rv, rand_mode;
    int              wait_cnt, op_id, refill_pct, rr_pct;
    logic [WIDTH-1:0] op_a, op_b;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++)
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_inputs();
        req_valid = pend;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = pa[i];
            req_b[i*WIDTH +: WIDTH] = pb[i];
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        pend[i] = 1'b1;
        pa[i]   = a;
        pb[i]   = b;
        drive_inputs();
    endtask

    task automatic rand_req(input int i);
        case ($urandom_range(0, 3))
            0:       set_req(i, 32'($urandom_range(0, 40)) - 32'd20, 32'($urandom_range(0, 40)) - 32'd20);
            1:       set_req(i, 32'h8000_0000, $urandom);
            default: set_req(i, $urandom, $urandom);
        endcase
    endtask

    // One clock: check at negedge against the model, advance the model, then drive.
    task automatic tick();
        logic [NREQ-1:0] exp_ready;
        logic [W-1:0]    e;
        int              g;
        @(negedge clk);
        exp_ready = '0;
        g = -1;
        if (!busy_op) begin
            g = rr_pick(pend, m_ptr);
            if (g >= 0) exp_ready = NREQ'(1 << g);
        end
        check_val("req_ready", req_ready, exp_ready);
        check_val("m_start", m_start, exp_start);
        if (exp_start || waiting) begin
            check_val("m_a", m_a, op_a);
            check_val("m_b", m_b, op_b);
        end
        check_val("resp_valid", resp_valid, exp_rv);
        if (exp_rv && exp_q.size() > 0) begin
            e = exp_q[0];
            check_val("resp_id", resp_id, e[W-2 -: IDW]);
            check_val("resp_data", resp_data, e[2*WIDTH-1:0]);
            check_val("resp_err", resp_err, e[W-1]);
        end

        if (exp_rv && resp_ready) begin
            void'(exp_q.pop_front());
            exp_rv  = 1'b0;
            busy_op = 1'b0;
            m_ptr   = (op_id + 1) % NREQ;
        end else if (exp_start) begin
            exp_start = 1'b0;
            waiting   = 1'b1;
            wait_cnt  = 0;
        end else if (waiting) begin
            if (m_done) begin
                waiting = 1'b0;
                exp_rv  = 1'b1;
                exp_q.push_back({1'b0, IDW'(op_id), ref_prod(op_a, op_b)});
            end else begin
                wait_cnt++;
                if (wait_cnt == TIMEOUT) begin
                    waiting = 1'b0;
                    exp_rv  = 1'b1;
                    exp_q.push_back({1'b1, IDW'(op_id), 64'd0});
                end
            end
        end
        if (g >= 0) begin
            busy_op   = 1'b1;
            op_id     = g;
            op_a      = pa[g];
            op_b      = pb[g];
            exp_start = 1'b1;
            pend[g]   = 1'b0;
        end

        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++)
            if (!pend[i] && $urandom_range(0, 99) < refill_pct) rand_req(i);
        if (rand_mode) mm_lat = $urandom_range(0, 6);
        resp_ready = ($urandom_range(0, 99) < rr_pct);
        drive_inputs();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while ((pend != 0 || busy_op) && n < max) begin
            tick();
            n++;
        end
        check_val("drain_idle", {59'd0, busy_op, pend}, 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_req_ready"}, req_ready, 0);
        check_val({tag, "_resp_valid"}, resp_valid, 0);
        check_val({tag, "_resp_id"}, resp_id, 0);
        check_val({tag, "_resp_data"}, resp_data, 0);
        check_val({tag, "_resp_err"}, resp_err, 0);
        check_val({tag, "_m_start"}, m_start, 0);
        check_val({tag, "_m_a"}, m_a, 0);
        check_val({tag, "_m_b"}, m_b, 0);
        check_val({tag, "_state"}, dbg_state, ST_IDLE);
    endtask

    task automatic model_reset();
        m_ptr     = 0;
        busy_op   = 1'b0;
        exp_start = 1'b0;
        waiting   = 1'b0;
        exp_rv    = 1'b0;
        wait_cnt  = 0;
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        resp_ready = 1'b0;
        pend = '0;
        for (int i = 0; i < NREQ; i++) begin
            pa[i] = '0;
            pb[i] = '0;
        end
        drive_inputs();
        mm_lat = 1; mm_hang = 1'b0; mm_spur = 1'b0;
        rand_mode = 1'b0; refill_pct = 0; rr_pct = 100;
        op_id = 0; op_a = '0; op_b = '0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed single requests, including signed corners.
        set_req(0, 32'd16, 32'd3);
        drain(100);
        set_req(2, 32'hFFFF_FFFB, 32'd7);
        drain(100);
        set_req(1, 32'h8000_0000, 32'h8000_0000);
        drain(100);

        // Contention: everyone valid continuously.
        mm_lat = 2;
        refill_pct = 100;
        for (int i = 0; i < NREQ; i++) rand_req(i);
        run(60);
        refill_pct = 0;
        drain(400);

        // Backpressure with another requester waiting.
        rr_pct = 0;
        set_req(3, $urandom, $urandom);
        set_req(0, $urandom, $urandom);
        run(16);
        rr_pct = 100;
        drain(200);

        // Watchdog, then normal service.
        mm_hang = 1'b1;
        set_req(1, 32'd9, 32'd9);
        drain(200);
        mm_hang = 1'b0;
        set_req(1, 32'd11, 32'hFFFF_FFFF);
        drain(100);

        // Completion on the last watchdog cycle, then one cycle too late.
        mm_lat = TIMEOUT - 1;
        set_req(2, 32'd123, 32'd456);
        drain(200);
        mm_lat = TIMEOUT;
        set_req(0, 32'd77, 32'd2);
        drain(200);

        // Spurious completion during the start pulse.
        mm_lat = 0;
        mm_spur = 1'b1;
        for (int i = 0; i < NREQ; i++) rand_req(i);
        drain(200);
        mm_spur = 1'b0;

        // Random traffic with random backpressure and latency.
        rand_mode = 1'b1;
        refill_pct = 30;
        rr_pct = 70;
        run(500);
        refill_pct = 0;
        drain(500);
        rand_mode = 1'b0;
        rr_pct = 100;

        // Reset in the middle of WAIT with another requester pending.
        mm_lat = 1;
        set_req(2, 32'd5, 32'd5);
        drain(100);
        mm_lat = 30;
        set_req(3, 32'd6, 32'd6);
        set_req(1, 32'd7, 32'd7);
        begin
            int n;
            n = 0;
            while (!(waiting && wait_cnt >= 3) && n < 50) begin
                tick();
                n++;
            end
        end
        check_val("reached_wait", {63'd0, waiting}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        pend = '0;
        drive_inputs();
        model_reset();
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        mm_lat = 1;
        set_req(1, 32'd3, 32'hFFFF_FFF0);
        set_req(3, 32'd4, 32'd4);
        drain(100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got t=%0t want completion", $time);
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/mult_sched.md
# mult_sched

Round-robin scheduler sharing the single sequential signed multiplier (`mult`, 32x32 -> 64) among NREQ requesters. Accepts operand pairs over per-requester valid/ready handshakes, issues one operation at a time to the multiplier, waits for completion (with watchdog), and returns the 64-bit product with the requester ID on one shared response channel. Sits between the client blocks and the multiplier datapath; the multiplier is never driven by anything else.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 32, operand width; product is 2*WIDTH
- TIMEOUT, 64, max cycles in WAIT before error response (must exceed multiplier latency)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  request present, one bit per requester
- req_ready  out  NREQ  one-hot accept pulse; transfer when valid&ready
- req_a  in  NREQ*WIDTH  signed operand A, requester i at [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  signed operand B, same packing
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- resp_id  out  clog2(NREQ)  requester index of response
- resp_data  out  2*WIDTH  signed product {hi,lo}
- resp_err  out  1  watchdog expired; resp_data = 0
- m_start  out  1  one-cycle start pulse to multiplier
- m_a, m_b  out  WIDTH  operands to multiplier, held stable from m_start until done/timeout
- m_done  in  1  multiplier result valid (pulse or level)
- m_lo, m_hi  in  WIDTH  multiplier product halves

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, grant g = first set bit searching upward from rr_ptr modulo NREQ; assert req_ready[g] this cycle (combinational from req_valid and rr_ptr); latch req_a/req_b slice g into m_a/m_b, latch g; -> ISSUE. No request: stay, all outputs idle.
- ISSUE: m_start=1 for exactly one cycle; clear watchdog counter; -> WAIT. m_done ignored in ISSUE.
- WAIT: on m_done: latch {m_hi,m_lo} into resp_data, resp_err=0; -> RESP. Else counter increments; when counter reaches TIMEOUT-1 without m_done: resp_data=0, resp_err=1; -> RESP.
- RESP: resp_valid=1, resp_id/resp_data/resp_err stable until resp_valid&resp_ready; then rr_ptr = (g+1) mod NREQ; -> IDLE. m_done during RESP ignored.
- Only one operation outstanding; req_ready is all zero outside IDLE.
- Product is taken verbatim from multiplier; no sign fixup in this block.
- Reset values: state IDLE, rr_ptr 0, req_ready 0, resp_valid 0, resp_id 0, resp_data 0, resp_err 0, m_start 0, m_a 0, m_b 0, counter 0.

## Timing
- Accept at cycle T (IDLE, valid&ready); m_start at T+1; m_done sampled from T+2; done seen at cycle D -> resp_valid at D+1.
- Back-to-back: response handshake at cycle R -> next accept earliest R+1 (IDLE cycle).
- Simultaneous requests: exactly one granted; others held pending (their valid must stay asserted; operands sampled only at grant).
- rr_ptr wraps NREQ-1 -> 0; updated only on response handshake, not on timeout alone.
- m_done and timeout in same cycle: m_done wins, resp_err=0.
- rst_n low mid-operation: immediately return to reset values; in-flight operation discarded, no response; multiplier must be reset by the same rst_n.

## Structure
- Package mult_sched_pkg: state encoding (IDLE/ISSUE/WAIT/RESP), default NREQ/WIDTH/TIMEOUT, ID width function.
- Sub-module rr_arbiter (req vector, ptr -> one-hot grant + index), purely combinational; FSM, counter and registers in mult_sched.

## Test plan
- Single request: requester 0, a=16, b=3 -> resp_id=0, resp_data=48, resp_err=0, exactly one m_start pulse.
- Signed: requester 2, a=-5, b=7 -> resp_data=0xFFFFFFFF_FFFFFFDD (-35); a=0x80000000, b=0x80000000 -> 0x40000000_00000000.
- Contention: all four valid continuously from reset -> grant order 0,1,2,3,0; no requester starved; req_ready one-hot.
- Backpressure: resp_ready low 10 cycles -> resp_valid, resp_id, resp_data stable; no new req_ready until handshake.
- Watchdog: model never asserts m_done, TIMEOUT=64 -> resp_err=1, resp_data=0 after 64 WAIT cycles; next request served normally.
- Reset mid-WAIT: drop rst_n during WAIT -> all outputs reset values asynchronously, no response emitted, rr_ptr=0 after release.
